char_action_sequencer: RTL and testbench
========================================

# char_action_sequencer

Frame-paced controller that turns the player's left/right/attack buttons into the 4-bit character state code and the one-cycle movement strobe consumed by the character position datapath. It sits between the button conditioning logic and the position/sprite blocks, and sequences the three-phase attack animations (start, active, recovery) from per-phase frame counts. All decisions are taken only on frame ticks, so movement speed and attack timing are frame-locked.

## Interface
- `ATK_START_FR`, 5: frames in S_ATTACK_START.
- `ATK_ACTIVE_FR`, 2: frames in S_ATTACK_ACTIVE.
- `ATK_RECOV_FR`, 16: frames in S_ATTACK_RECOVERY.
- `DIR_START_FR`, 4: frames in S_ATTACK_DIR_START.
- `DIR_ACTIVE_FR`, 3: frames in S_ATTACK_DIR_ACTIVE.
- `DIR_RECOV_FR`, 15: frames in S_ATTACK_DIR_RECOVERY. All frame counts are 1..31.
- `clk`  in  1: system clock. One clock domain only.
- `rst`  in  1: reset, asynchronous and active-high.
- `frame_tick`  in  1: one-cycle pulse, once per video frame.
- `btn_left`  in  1: left button level, already synchronised and debounced.
- `btn_right`  in  1: right button level, already synchronised and debounced.
- `btn_attack`  in  1: attack button level, already synchronised and debounced.
- `state`  out  4: state code. Encodings: IDLE 0, LEFT 1, RIGHT 2, ATTACK_START 3, ATTACK_ACTIVE 4, ATTACK_RECOVERY 5, DIR_START 6, DIR_ACTIVE 7, DIR_RECOVERY 8.
- `move_flag`  out  1: one-cycle strobe that authorises one position step.
- `hit_active`  out  1: high while state is ATTACK_ACTIVE or DIR_ACTIVE.
- `busy`  out  1: high in any attack state (codes 3..8).

## Operation
- **Reset.** While `rst` is high, all outputs are forced immediately (asynchronously) to the following values:
  - `state` = IDLE, `move_flag` = 0, `hit_active` = 0, `busy` = 0.
  - The frame counter and the attack-pending flag are cleared.
- **Attack request capture.**
  - A `btn_attack` rising edge is detected every clk against a registered copy of the button.
  - When `busy` = 0, the edge sets `atk_pend`.
  - Edges seen while `busy` = 1 are discarded; attacks are not buffered.
  - `atk_pend` is cleared when it is consumed.
- **Evaluation.** All state transitions occur only on clk edges where `frame_tick` = 1. Between ticks, `state` holds.
- **Free states (IDLE/LEFT/RIGHT), on a tick.** Checks are applied in this priority order:
  1. `atk_pend` = 1 and exactly one direction button is held: go to DIR_START and consume `atk_pend`.
  2. `atk_pend` = 1 otherwise: go to ATTACK_START and consume `atk_pend`.
  3. `btn_left` = 1 and `btn_right` = 0: go to LEFT.
  4. `btn_right` = 1 and `btn_left` = 0: go to RIGHT.
  5. Otherwise (no button, or both direction buttons): go to IDLE.
- **Attack phases.**
  - On entry to a phase, the 5-bit `frame_cnt` loads that phase's parameter minus 1.
  - On each tick, if `frame_cnt` ≠ 0 it decrements; if it is 0, the FSM advances.
  - Plain attack path: START → ACTIVE → RECOVERY → free-state evaluation.
  - Directional attack path: DIR_START → DIR_ACTIVE → DIR_RECOVERY → free-state evaluation.
  - Each phase therefore lasts exactly its parameter value in ticks.
  - Leaving RECOVERY applies the free-state rules on that same tick, so a held direction goes straight to LEFT/RIGHT. `atk_pend` is always 0 at this point.
- **move_flag.** Registered; equals 1 for exactly the one clk following a tick whose next state is LEFT or RIGHT. It is 0 in all other cycles.
- **Direction changes.** Button changes mid-attack have no effect. Directions are sampled only at tick edges in free states.

## Timing
- `state`, `move_flag`, `hit_active` and `busy` are all registered. They update on the clk edge where `frame_tick` = 1 and are valid from the following cycle.
- `move_flag` is asserted in the same cycle that `state` first shows LEFT/RIGHT (or continues in it). The position datapath therefore sees a consistent {state, flag} pair.
- Attack latency:
  - The edge is captured 1 clk after `btn_attack` rises.
  - The START state appears after the next tick edge.
- Total attack duration is START+ACTIVE+RECOVERY ticks; with default parameters this is 23 ticks for a plain attack and 22 for a directional one.
- Reset asserted mid-attack aborts it: outputs take their reset values at once, and a pending request is lost.
- If `frame_tick` and a `btn_attack` edge land on the same clk, the request is taken on the following tick, not the current one.

## Test plan
- **Reset and idle.** Pulse `rst` mid-frame, no buttons, 5 ticks → `state` = 0, `move_flag` never 1, `busy` = 0 throughout.
- **Hold right.** Hold `btn_right` for 10 ticks → `state` = 2 after the first tick edge; exactly 10 `move_flag` pulses, each 1 clk wide and coincident with `state` = 2.
- **Both directions.** Press left and right together → `state` stays 0 and `move_flag` stays 0. Release right → LEFT on the next tick.
- **Plain attack.** Give an attack edge with no direction held → sequence 3 for 5 ticks, 4 for 2 ticks with `hit_active` = 1, 5 for 16 ticks, then 0. `busy` = 1 for exactly 23 ticks.
- **Directional attack and discard.** Hold `btn_left` and give an attack edge → states 6/7/8 for 4/3/15 ticks. A second attack edge during state 7 is discarded, and the FSM ends in LEFT, not a new attack.
- **Async reset.** Assert `rst` during state 4, between clk edges → `state` = 0 and `hit_active` = 0 before the next clk edge.

Source files
------------

// File: rtl/char_action_sequencer_if.sv
// Signal bundle between the button conditioning / frame timing side (master)
// and the character action sequencer (slave).
// The inputs carry no handshake: frame_tick is a one-cycle pulse per video
// frame and the buttons are clean levels. The outputs are registered and
// valid from the cycle after the clk edge that updates them.
interface char_action_sequencer_if;
   logic       frame_tick;
   logic       btn_left;
   logic       btn_right;
   logic       btn_attack;
   logic [3:0] state;
   logic       move_flag;
   logic       hit_active;
   logic       busy;

   modport master (
      output frame_tick, btn_left, btn_right, btn_attack,
      input  state, move_flag, hit_active, busy
   );

   modport slave (
      input  frame_tick, btn_left, btn_right, btn_attack,
      output state, move_flag, hit_active, busy
   );
endinterface

// File: rtl/char_action_sequencer.sv
// Frame-paced character action sequencer: turns left/right/attack buttons
// into a 4-bit character state code plus a one-cycle movement strobe, and
// times the three-phase attack animations in frames. The state register is
// presented directly on bus.state, so it doubles as the FSM debug view.
module char_action_sequencer #(
   parameter int ATK_START_FR  = 5,
   parameter int ATK_ACTIVE_FR = 2,
   parameter int ATK_RECOV_FR  = 16,
   parameter int DIR_START_FR  = 4,
   parameter int DIR_ACTIVE_FR = 3,
   parameter int DIR_RECOV_FR  = 15
) (
   input logic                     clk,
   input logic                     rst,
   char_action_sequencer_if.slave  bus
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_LEFT       = 4'd1,
      S_RIGHT      = 4'd2,
      S_ATK_START  = 4'd3,
      S_ATK_ACTIVE = 4'd4,
      S_ATK_RECOV  = 4'd5,
      S_DIR_START  = 4'd6,
      S_DIR_ACTIVE = 4'd7,
      S_DIR_RECOV  = 4'd8
   } state_t;

   // Counter reload values: a phase of N frames counts N-1 down to 0.
   localparam logic [4:0] ATK_START_M1  = 5'(ATK_START_FR - 1);
   localparam logic [4:0] ATK_ACTIVE_M1 = 5'(ATK_ACTIVE_FR - 1);
   localparam logic [4:0] ATK_RECOV_M1  = 5'(ATK_RECOV_FR - 1);
   localparam logic [4:0] DIR_START_M1  = 5'(DIR_START_FR - 1);
   localparam logic [4:0] DIR_ACTIVE_M1 = 5'(DIR_ACTIVE_FR - 1);
   localparam logic [4:0] DIR_RECOV_M1  = 5'(DIR_RECOV_FR - 1);

   state_t     state_q, state_d;
   logic [4:0] frame_cnt_q, frame_cnt_d;
   logic       atk_pend_q, atk_pend_d;
   logic       btn_attack_q;
   logic       move_q, move_d;
   logic       hit_q, hit_d;
   logic       busy_q, busy_d;
   logic       atk_edge;
   logic       consume;
   logic       do_free;
   logic       one_dir;

   assign atk_edge = bus.btn_attack & ~btn_attack_q;
   assign one_dir  = bus.btn_left ^ bus.btn_right;

   // Next state, phase counter and pending-attack bookkeeping.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      consume     = 1'b0;
      do_free     = 1'b0;

      if (bus.frame_tick) begin
         unique case (state_q)
            S_IDLE, S_LEFT, S_RIGHT: do_free = 1'b1;
            S_ATK_START: begin
               if (frame_cnt_q != 5'd0) frame_cnt_d = frame_cnt_q - 5'd1;
               else begin
                  state_d     = S_ATK_ACTIVE;
                  frame_cnt_d = ATK_ACTIVE_M1;
               end
            end
            S_ATK_ACTIVE: begin
               if (frame_cnt_q != 5'd0) frame_cnt_d = frame_cnt_q - 5'd1;
               else begin
                  state_d     = S_ATK_RECOV;
                  frame_cnt_d = ATK_RECOV_M1;
               end
            end
            S_DIR_START: begin
               if (frame_cnt_q != 5'd0) frame_cnt_d = frame_cnt_q - 5'd1;
               else begin
                  state_d     = S_DIR_ACTIVE;
                  frame_cnt_d = DIR_ACTIVE_M1;
               end
            end
            S_DIR_ACTIVE: begin
               if (frame_cnt_q != 5'd0) frame_cnt_d = frame_cnt_q - 5'd1;
               else begin
                  state_d     = S_DIR_RECOV;
                  frame_cnt_d = DIR_RECOV_M1;
               end
            end
            // Leaving recovery re-evaluates the buttons on the same tick.
            S_ATK_RECOV, S_DIR_RECOV: begin
               if (frame_cnt_q != 5'd0) frame_cnt_d = frame_cnt_q - 5'd1;
               else                     do_free     = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase

         if (do_free) begin
            frame_cnt_d = 5'd0;
            if (atk_pend_q && one_dir) begin
               state_d     = S_DIR_START;
               frame_cnt_d = DIR_START_M1;
               consume     = 1'b1;
            end else if (atk_pend_q) begin
               state_d     = S_ATK_START;
               frame_cnt_d = ATK_START_M1;
               consume     = 1'b1;
            end else if (bus.btn_left && !bus.btn_right) begin
               state_d = S_LEFT;
            end else if (bus.btn_right && !bus.btn_left) begin
               state_d = S_RIGHT;
            end else begin
               state_d = S_IDLE;
            end
         end
      end

      // A request consumed now must not be re-armed by an edge in the same
      // cycle; edges during an attack are dropped, never queued.
      if (consume)                  atk_pend_d = 1'b0;
      else if (atk_edge && !busy_q) atk_pend_d = 1'b1;
      else                          atk_pend_d = atk_pend_q;

      move_d = bus.frame_tick && ((state_d == S_LEFT) || (state_d == S_RIGHT));
      hit_d  = (state_d == S_ATK_ACTIVE) || (state_d == S_DIR_ACTIVE);
      busy_d = (state_d >= S_ATK_START) && (state_d <= S_DIR_RECOV);
   end

   // State, counter, request capture and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         frame_cnt_q  <= 5'd0;
         atk_pend_q   <= 1'b0;
         btn_attack_q <= 1'b0;
         move_q       <= 1'b0;
         hit_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         atk_pend_q   <= atk_pend_d;
         btn_attack_q <= bus.btn_attack;
         move_q       <= move_d;
         hit_q        <= hit_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.move_flag  = move_q;
   assign bus.hit_active = hit_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_char_action_sequencer.sv
// Testbench for char_action_sequencer: directed scenarios plus randomized
// button/tick traffic, checked every cycle against a frame-level model that
// expands each attack into a list of per-tick state codes.
module tb_char_action_sequencer;

   logic clk;
   logic rst;
   char_action_sequencer_if bus ();

   char_action_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_errors;

   // Reference model state
   int m_state;
   int plan[$];
   bit m_pend;
   bit m_prev_atk;
   bit m_move;

   // Observations
   int obs_busy;
   int busy_ticks;
   int move_pulses;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state    = 0;
      plan.delete();
      m_pend     = 0;
      m_prev_atk = 0;
      m_move     = 0;
   endtask

   // Queue the remaining per-tick codes of an attack whose first phase has
   // just been entered (that entry tick already shows the first code).
   task automatic plan_attack(input int c0, input int n0, input int n1, input int n2);
      plan.delete();
      for (int i = 0; i < n0 - 1; i++) plan.push_back(c0);
      for (int i = 0; i < n1; i++)     plan.push_back(c0 + 1);
      for (int i = 0; i < n2; i++)     plan.push_back(c0 + 2);
   endtask

   // One clk edge of the behavioural model.
   task automatic model_edge(input bit tick, input bit l, input bit r, input bit a);
      bit edge_seen;
      bit busy_now;
      bit consumed;
      edge_seen = a && !m_prev_atk;
      busy_now  = (m_state >= 3);
      consumed  = 0;
      if (tick) begin
         if (plan.size() > 0) begin
            m_state = plan.pop_front();
         end else if (m_pend) begin
            consumed = 1;
            if (l != r) begin
               m_state = 6;
               plan_attack(6, 4, 3, 15);
            end else begin
               m_state = 3;
               plan_attack(3, 5, 2, 16);
            end
         end else if (l && !r) m_state = 1;
         else if (r && !l)     m_state = 2;
         else                  m_state = 0;
         m_move = (m_state == 1) || (m_state == 2);
      end else begin
         m_move = 0;
      end
      if (consumed)                    m_pend = 0;
      else if (edge_seen && !busy_now) m_pend = 1;
      m_prev_atk = a;
   endtask

   task automatic check_outputs();
      check("state", int'(bus.state), m_state);
      check("move_flag", int'(bus.move_flag), int'(m_move));
      check("hit_active", int'(bus.hit_active), int'(m_state == 4 || m_state == 7));
      check("busy", int'(bus.busy), int'(m_state >= 3));
      obs_busy = int'(bus.busy);
      if (bus.move_flag) move_pulses++;
   endtask

   // Driver: one clk cycle with the given inputs, then model and check.
   task automatic cycle(input bit tick, input bit l, input bit r, input bit a);
      bus.frame_tick = tick;
      bus.btn_left   = l;
      bus.btn_right  = r;
      bus.btn_attack = a;
      if (tick && obs_busy == 1) busy_ticks++;
      @(posedge clk);
      model_edge(tick, l, r, a);
      @(negedge clk);
      check_outputs();
   endtask

   // n frames of 4 cycles, tick in the first cycle, buttons held.
   task automatic frames(input int n, input bit l, input bit r, input bit a);
      for (int f = 0; f < n; f++)
         for (int c = 0; c < 4; c++) cycle(c == 0, l, r, a);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.frame_tick = 1'b0;
      #1;
      check("rst_state", int'(bus.state), 0);
      check("rst_move", int'(bus.move_flag), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      obs_busy = 0;
   endtask

   initial begin
      bit l, r, a;
      bit reached;
      int period;
      n_checks = 0;
      n_errors = 0;
      busy_ticks = 0;
      move_pulses = 0;
      obs_busy = 0;
      model_reset();
      rst = 1'b1;
      bus.frame_tick = 1'b0;
      bus.btn_left   = 1'b0;
      bus.btn_right  = 1'b0;
      bus.btn_attack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset mid-frame, then idle frames
      cycle(1'b1, 0, 0, 0);
      cycle(1'b0, 0, 0, 0);
      apply_reset();
      move_pulses = 0;
      frames(5, 0, 0, 0);
      check("idle_moves", move_pulses, 0);

      // Hold right for 10 ticks
      move_pulses = 0;
      frames(10, 0, 1, 0);
      check("right_moves", move_pulses, 10);
      frames(1, 0, 0, 0);

      // Both directions, then release right
      move_pulses = 0;
      frames(3, 1, 1, 0);
      check("both_moves", move_pulses, 0);
      frames(2, 1, 0, 0);
      check("left_after_release", int'(bus.state), 1);
      frames(1, 0, 0, 0);

      // Plain attack
      busy_ticks = 0;
      frames(1, 0, 0, 1);
      frames(30, 0, 0, 0);
      check("plain_busy_ticks", busy_ticks, 23);
      check("plain_end_idle", int'(bus.state), 0);

      // Directional attack with a discarded second press during DIR_ACTIVE
      busy_ticks = 0;
      frames(1, 1, 0, 1);
      reached = 0;
      for (int i = 0; i < 20 && !reached; i++) begin
         frames(1, 1, 0, 0);
         if (m_state == 7) reached = 1;
      end
      check("reach_dir_active", int'(reached), 1);
      frames(1, 1, 0, 1);
      frames(25, 1, 0, 0);
      check("dir_busy_ticks", busy_ticks, 22);
      check("dir_end_left", int'(bus.state), 1);
      frames(1, 0, 0, 0);

      // Async reset during ATTACK_ACTIVE, between clk edges
      frames(1, 0, 0, 1);
      reached = 0;
      for (int i = 0; i < 20 && !reached; i++) begin
         frames(1, 0, 0, 0);
         if (m_state == 4) reached = 1;
      end
      check("reach_active", int'(reached), 1);
      check("hit_before_rst", int'(bus.hit_active), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_state", int'(bus.state), 0);
      check("async_hit", int'(bus.hit_active), 0);
      check("async_busy", int'(bus.busy), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      obs_busy = 0;
      frames(3, 0, 0, 0);

      // Randomized traffic with varying frame length
      l = 0; r = 0; a = 0;
      for (int f = 0; f < 300; f++) begin
         period = $urandom_range(2, 5);
         if ($urandom_range(0, 2) == 0) l = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) r = 1'($urandom_range(0, 1));
         for (int c = 0; c < period; c++) begin
            if ($urandom_range(0, 4) == 0) a = ~a;
            cycle(c == 0, l, r, a);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
